// File: rtl/out_port_alloc.sv
// Per-output-port wormhole allocator: round-robin among matching inputs, packet lock head-to-tail, credit-gated grants.
// Optional stall detector built only when ALLOC_TIMEOUT_EN is defined.
module out_port_alloc #(
  parameter int NPORT   = 5,
  parameter int PORTW   = 3,
  parameter int PORTID  = 0,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst_,
  input  logic [NPORT*PORTW-1:0] req_port,
  input  logic [NPORT-1:0]       req,
  input  logic [NPORT-1:0]       tail,
  input  logic                   credit_ok,
  output logic [NPORT-1:0]       sel,
  output logic [NPORT-1:0]       grt,
  output logic                   busy,
  output logic                   stall_err
);

  localparam int IDXW = $clog2(NPORT);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t           state, state_nxt;
  logic [IDXW-1:0]  owner, owner_nxt;
  logic [IDXW-1:0]  rr_ptr, rr_ptr_nxt;
  logic [IDXW-1:0]  winner;
  logic             win_found;
  logic [NPORT-1:0] mreq;
  int               idx;

  always_comb begin
    mreq = '0;
    for (int i = 0; i < NPORT; i++) begin
      mreq[i] = req[i] && (req_port[i*PORTW +: PORTW] == PORTW'(PORTID));
    end
  end

  // Rotating search starting at rr_ptr; first hit wins, so ties cannot occur.
  always_comb begin
    winner    = '0;
    win_found = 1'b0;
    idx       = 0;
    for (int k = 0; k < NPORT; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NPORT) idx = idx - NPORT;
      if (!win_found && mreq[idx]) begin
        win_found = 1'b1;
        winner    = IDXW'(idx);
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    owner_nxt  = owner;
    rr_ptr_nxt = rr_ptr;
    sel        = '0;
    case (state)
      IDLE: begin
        if (win_found) begin
          sel[winner] = 1'b1;
          if (credit_ok) begin
            rr_ptr_nxt = (winner == IDXW'(NPORT-1)) ? '0 : winner + 1'b1;
            if (!tail[winner]) begin
              state_nxt = LOCKED;
              owner_nxt = winner;
            end
          end
        end
      end
      LOCKED: begin
        // Owner dropping its request (abort or reroute) releases the lock without a grant.
        if (mreq[owner]) begin
          sel[owner] = 1'b1;
          if (credit_ok && tail[owner]) state_nxt = IDLE;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign grt  = sel & {NPORT{credit_ok}};
  assign busy = (state == LOCKED);

  always_ff @(posedge clk) begin
    if (rst_) begin
      state  <= IDLE;
      owner  <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_nxt;
      owner  <= owner_nxt;
      rr_ptr <= rr_ptr_nxt;
    end
  end

`ifdef ALLOC_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] stall_cnt, stall_cnt_nxt;
  logic          stall_err_q;

  // A stall is a selected flit with no credit; every other cycle is a transfer or has no request.
  always_comb begin
    stall_cnt_nxt = '0;
    if ((sel != '0) && !credit_ok) begin
      stall_cnt_nxt = (stall_cnt == CW'(TIMEOUT)) ? stall_cnt : stall_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_) begin
      stall_cnt   <= '0;
      stall_err_q <= 1'b0;
    end else begin
      stall_cnt   <= stall_cnt_nxt;
      stall_err_q <= stall_err_q || (stall_cnt_nxt == CW'(TIMEOUT));
    end
  end

  assign stall_err = stall_err_q;
`else
  assign stall_err = 1'b0;
`endif

endmodule

// File: doc/out_port_alloc.md
Name: out_port_alloc

Overview:
- Parametrised per-output-port allocator for the mesh router; one instance per output port.
- Each input port presents its routed destination port and a request.
- The block arbitrates round-robin among the inputs that target this port's PORTID.
- The winner is locked for the whole wormhole packet (head to tail), and every flit transfer is gated on downstream credit.
- It drives the crossbar mux select and per-input grants.

Parameters:
- NPORT, 5, number of input ports (2..16).
- PORTW, 3, width of each destination-port field.
- PORTID, 0, this output port's ID; only requests whose destination equals PORTID are considered.
- TIMEOUT, 64, stall-detect threshold in cycles (only used with ALLOC_TIMEOUT_EN).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_  in  1  reset, synchronous, active-high.
- req_port  in  NPORT*PORTW  destination port per input; input i occupies bits [i*PORTW +: PORTW].
- req  in  NPORT  flit valid / request per input.
- tail  in  NPORT  asserted with req when the presented flit is the packet's tail; head+tail together means a single-flit packet.
- credit_ok  in  1  downstream buffer can accept one flit this cycle.
- sel  out  NPORT  one-hot crossbar select (current winner or owner); zero if none.
- grt  out  NPORT  one-hot flit transfer grant, equal to sel & credit_ok; input i dequeues a flit when grt[i]=1.
- busy  out  1  a packet lock is held.
- stall_err  out  1  sticky stall flag (ALLOC_TIMEOUT_EN only; tied 0 otherwise).

Behaviour:
- Matching request: mreq[i] = req[i] & (req_port[i] == PORTID).
- State: IDLE / LOCKED; owner index register; rr_ptr register (0..NPORT-1).
- Reset values: IDLE, owner=0, rr_ptr=0, stall counter=0, stall_err=0. Consequently sel=0, grt=0, busy=0 whenever no matching request is present.
- IDLE, winner selection:
  - winner = first i with mreq[i]=1, searching rr_ptr, rr_ptr+1, … modulo NPORT.
  - sel = onehot(winner) combinationally, same cycle as the request (0-cycle latency).
  - grt = sel only if credit_ok=1.
- IDLE, on a transfer (grt≠0):
  - Winner's tail=1 (single-flit packet): stay IDLE.
  - Winner's tail=0: go LOCKED with owner=winner.
  - In both cases rr_ptr <= (winner+1) mod NPORT.
- IDLE with credit_ok=0: no state change and rr_ptr unchanged; the winner may change next cycle.
- LOCKED, select and grant:
  - sel = onehot(owner) while mreq[owner]=1.
  - Other inputs are masked even if they match.
  - grt = sel & credit_ok.
- LOCKED, on a transfer with tail[owner]=1: go IDLE next cycle. No other input is granted in that same cycle.
- LOCKED, if mreq[owner] drops (abort, or destination changed): sel=0, grt=0, go IDLE next cycle; rr_ptr is unchanged.
- busy = (state == LOCKED).
- grt is always one-hot or zero; sel is never multi-hot.
- rr_ptr wraps from NPORT-1 to 0.
- rst_ asserted mid-packet: back to IDLE with all registers at reset values on the next edge; the lock is lost.
- Simultaneous requests: resolved by rr_ptr as above. Ties are impossible because the search order is total.

Optional Feature:
- Macro: ALLOC_TIMEOUT_EN.
- When defined:
  - A counter, saturating at TIMEOUT, increments each cycle that mreq[owner]=1 while LOCKED and credit_ok=0 (or while IDLE with a winner and credit_ok=0).
  - It clears on any transfer, on returning to IDLE with no request, and on reset.
  - When it reaches TIMEOUT, stall_err is set and held until reset.
  - Arbitration is unaffected.
- When undefined: no counter is built and stall_err is constant 0.

Test Plan:
- Reset then idle: rst_=1 for 2 cycles, then all req=0 -> sel=0, grt=0, busy=0, stall_err=0.
- Round-robin on single-flit packets: PORTID=0, inputs 1, 2 and 4 request port 0 with tail=1 every cycle, credit_ok=1 -> grant order 1,2,4,1,2,4, one grant per cycle.
- Wormhole lock: input 3 sends a 4-flit packet (tail on flit 4) while input 1 also requests port 0 -> grt=onehot(3) for 4 transfers, busy=1 through the tail cycle, input 1 granted on the next cycle.
- Credit backpressure: input 2 locked, credit_ok=0 for 5 cycles -> sel=onehot(2), grt=0, state held; on credit_ok=1 the remaining flits transfer in order.
- Non-matching and abort: input 0 requests port 3 (ignored); input 4 locked then drops req mid-packet -> grt=0 that cycle, IDLE next, rr_ptr unchanged.
- Timeout (ALLOC_TIMEOUT_EN, TIMEOUT=8): locked owner with credit_ok=0 for 8 cycles -> stall_err=1 after cycle 8, remains 1 after credit returns until rst_.
